// File: rtl/apb_irq_ctrl.sv
// rtl/apb_irq_ctrl.sv - APB-mapped prioritised interrupt controller
module apb_irq_ctrl #(
  parameter int NrIrqs    = 16,
  parameter int PrioWidth = 3,
  parameter int IdWidth   = (NrIrqs > 1) ? $clog2(NrIrqs) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [31:0]          paddr_i,
  input  logic [31:0]          pwdata_i,
  output logic [31:0]          prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  input  logic [NrIrqs-1:0]    irq_i,
  output logic                 irq_valid_o,
  output logic [IdWidth-1:0]   irq_id_o,
  output logic [PrioWidth-1:0] irq_prio_o,
  input  logic                 irq_ack_i,
  input  logic [IdWidth-1:0]   irq_ack_id_i
);

  localparam logic [9:0] ThreshWord = 10'd64;

  // Per-line state and registered arbitration result
  logic [NrIrqs-1:0]                ip_q, ip_d;
  logic [NrIrqs-1:0]                ie_q, ie_d;
  logic [NrIrqs-1:0]                trig_q, trig_d;
  logic [NrIrqs-1:0][PrioWidth-1:0] prio_q, prio_d;
  logic [PrioWidth-1:0]             thresh_q, thresh_d;
  logic [NrIrqs-1:0]                irq_prev_q, irq_prev_d;
  logic                             irq_valid_q, irq_valid_d;
  logic [IdWidth-1:0]               irq_id_q, irq_id_d;
  logic [PrioWidth-1:0]             irq_prio_q, irq_prio_d;

  logic       access;
  logic [9:0] word;
  logic       unused_bits;

  assign access   = psel_i & penable_i;
  assign word     = paddr_i[11:2];
  assign pready_o = 1'b1;

  assign unused_bits = ^{paddr_i[31:12], paddr_i[1:0], pwdata_i[31:8+PrioWidth], pwdata_i[7:3]};

  // Read mux and error flag, combinational from the address and current state
  always_comb begin
    prdata_o  = '0;
    pslverr_o = 1'b0;
    if (access) begin
      pslverr_o = 1'b1;
      if (word == ThreshWord) begin
        pslverr_o = 1'b0;
        prdata_o[PrioWidth-1:0] = thresh_q;
      end
      for (int i = 0; i < NrIrqs; i++) begin
        if (word == 10'(i)) begin
          pslverr_o             = 1'b0;
          prdata_o[0]           = ip_q[i];
          prdata_o[1]           = ie_q[i];
          prdata_o[2]           = trig_q[i];
          prdata_o[8 +: PrioWidth] = prio_q[i];
        end
      end
    end
  end

  // Next-state: software write, then ack clear, then set event (set always wins)
  always_comb begin
    logic set_ev;
    logic wr;
    ip_d       = ip_q;
    ie_d       = ie_q;
    trig_d     = trig_q;
    prio_d     = prio_q;
    thresh_d   = thresh_q;
    irq_prev_d = irq_i;
    set_ev     = 1'b0;
    wr         = 1'b0;
    if (access && pwrite_i && word == ThreshWord) begin
      thresh_d = pwdata_i[PrioWidth-1:0];
    end
    for (int i = 0; i < NrIrqs; i++) begin
      wr     = access & pwrite_i & (word == 10'(i));
      set_ev = trig_q[i] ? (irq_i[i] & ~irq_prev_q[i]) : irq_i[i];
      if (wr) begin
        ip_d[i]   = pwdata_i[0];
        ie_d[i]   = pwdata_i[1];
        trig_d[i] = pwdata_i[2];
        prio_d[i] = pwdata_i[8 +: PrioWidth];
      end else if (irq_ack_i && irq_ack_id_i == IdWidth'(i)) begin
        ip_d[i] = 1'b0;
      end
      ip_d[i] = ip_d[i] | set_ev;
    end
  end

  // Arbitration on next-state values: highest priority, lowest index on ties
  always_comb begin
    irq_valid_d = 1'b0;
    irq_id_d    = '0;
    irq_prio_d  = '0;
    for (int i = 0; i < NrIrqs; i++) begin
      if (ip_d[i] && ie_d[i] && (prio_d[i] > thresh_d) &&
          (!irq_valid_d || prio_d[i] > irq_prio_d)) begin
        irq_valid_d = 1'b1;
        irq_id_d    = IdWidth'(i);
        irq_prio_d  = prio_d[i];
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ip_q        <= '0;
      ie_q        <= '0;
      trig_q      <= '0;
      prio_q      <= '0;
      thresh_q    <= '0;
      irq_prev_q  <= '0;
      irq_valid_q <= 1'b0;
      irq_id_q    <= '0;
      irq_prio_q  <= '0;
    end else begin
      ip_q        <= ip_d;
      ie_q        <= ie_d;
      trig_q      <= trig_d;
      prio_q      <= prio_d;
      thresh_q    <= thresh_d;
      irq_prev_q  <= irq_prev_d;
      irq_valid_q <= irq_valid_d;
      irq_id_q    <= irq_id_d;
      irq_prio_q  <= irq_prio_d;
    end
  end

  assign irq_valid_o = irq_valid_q;
  assign irq_id_o    = irq_id_q;
  assign irq_prio_o  = irq_prio_q;

endmodule

// File: tb/tb_apb_irq_ctrl.sv
// tb/tb_apb_irq_ctrl.sv - directed self-checking bench for apb_irq_ctrl
module tb_apb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;
  logic [15:0] irq;
  logic        irq_valid;
  logic [3:0]  irq_id;
  logic [2:0]  irq_prio;
  logic        ack;
  logic [3:0]  ack_id;

  int total = 0;
  int bad   = 0;

  apb_irq_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
    .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
    .pready_o(pready), .pslverr_o(pslverr),
    .irq_i(irq), .irq_valid_o(irq_valid), .irq_id_o(irq_id), .irq_prio_o(irq_prio),
    .irq_ack_i(ack), .irq_ack_id_i(ack_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input int w, input logic [31:0] d);
    psel = 1; penable = 1; pwrite = 1; paddr = 32'(w) << 2; pwdata = d;
    tick();
    psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
  endtask

  task automatic apb_read(input int w, output logic [31:0] d, output logic e);
    psel = 1; penable = 1; pwrite = 0; paddr = 32'(w) << 2;
    #1;
    d = prdata; e = pslverr;
    psel = 0; penable = 0; paddr = '0;
    #1;
  endtask

  task automatic check_out(input string name, input logic v, input logic [3:0] id, input logic [2:0] p);
    total++;
    if ({irq_valid, irq_id, irq_prio} !== {v, id, p}) begin
      bad++;
      $display("FAIL %s got v=%b id=%0d prio=%0d exp v=%b id=%0d prio=%0d",
               name, irq_valid, irq_id, irq_prio, v, id, p);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e;
    rst_n = 0; tick(); tick(); rst_n = 1;
    check_out("reset_out", 0, 0, 0);
    total++;
    if ({pslverr, prdata, pready} !== {1'b0, 32'h0, 1'b1}) begin
      bad++; $display("FAIL reset_idle got err=%b rd=%h rdy=%b exp 0/0/1", pslverr, prdata, pready);
    end
    for (int i = 0; i < 16; i++) begin
      apb_read(i, d, e);
      total++;
      if ({e, d} !== 33'h0) begin
        bad++; $display("FAIL reset_line%0d got err=%b d=%h exp 0/0", i, e, d);
      end
    end
    apb_read(64, d, e);
    total++;
    if ({e, d} !== 33'h0) begin
      bad++; $display("FAIL reset_thresh got err=%b d=%h exp 0/0", e, d);
    end
    apb_read(128, d, e);
    total++;
    if ({e, d} !== {1'b1, 32'h0}) begin
      bad++; $display("FAIL unmapped_rd got err=%b d=%h exp 1/0", e, d);
    end
  endtask

  task automatic test_edge();
    logic [31:0] d; logic e;
    tick();
    apb_write(3, 32'h506);
    irq[3] = 1; tick(); irq[3] = 0;
    check_out("edge_set", 1, 3, 5);
    tick();
    check_out("edge_hold", 1, 3, 5);
    ack = 1; ack_id = 3; tick(); ack = 0; ack_id = 0;
    check_out("edge_ack", 0, 0, 0);
    apb_read(3, d, e);
    total++;
    if (d !== 32'h506) begin
      bad++; $display("FAIL edge_ip_rd got %h exp %h", d, 32'h506);
    end
  endtask

  task automatic test_priority();
    tick();
    apb_write(2, 32'h403);
    check_out("prio_single", 1, 2, 4);
    apb_write(7, 32'h403);
    check_out("prio_tie", 1, 2, 4);
    apb_write(9, 32'h603);
    check_out("prio_high", 1, 9, 6);
    apb_write(9, 32'h602);
    check_out("prio_clear9", 1, 2, 4);
    apb_write(2, 32'h402);
    check_out("prio_clear2", 1, 7, 4);
    apb_write(7, 0); apb_write(9, 0); apb_write(2, 0);
    check_out("prio_none", 0, 0, 0);
  endtask

  task automatic test_thresh();
    logic [31:0] d; logic e;
    tick();
    apb_write(64, 4);
    apb_write(1, 32'h403);
    check_out("thr_eq_mask", 0, 0, 0);
    apb_read(64, d, e);
    total++;
    if ({e, d} !== {1'b0, 32'h4}) begin
      bad++; $display("FAIL thr_read got err=%b d=%h exp 0/4", e, d);
    end
    apb_write(64, 3);
    check_out("thr_below", 1, 1, 4);
    apb_write(1, 32'h703);
    apb_write(64, 7);
    check_out("thr_max_mask", 0, 0, 0);
    apb_write(64, 0);
    check_out("thr_zero", 1, 1, 7);
    apb_write(1, 0);
    apb_write(4, 32'h003);
    check_out("prio_zero", 0, 0, 0);
    apb_write(4, 0);
  endtask

  task automatic test_level_ack();
    logic [31:0] d; logic e;
    tick();
    apb_write(5, 32'h302);
    irq[5] = 1; tick();
    check_out("lvl_set", 1, 5, 3);
    ack = 1; ack_id = 5; tick(); ack = 0; ack_id = 0;
    check_out("lvl_ack_repend", 1, 5, 3);
    apb_read(5, d, e);
    total++;
    if (d !== 32'h303) begin
      bad++; $display("FAIL lvl_ip_rd got %h exp %h", d, 32'h303);
    end
    apb_write(6, 32'h406);
    irq[6] = 1; ack = 1; ack_id = 6; tick(); irq[6] = 0; ack = 0; ack_id = 0;
    check_out("edge_vs_ack", 1, 6, 4);
    apb_read(6, d, e);
    total++;
    if (d !== 32'h407) begin
      bad++; $display("FAIL edge_vs_ack_rd got %h exp %h", d, 32'h407);
    end
    irq[5] = 0;
    apb_write(5, 0); apb_write(6, 0);
    check_out("lvl_clean", 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e;
    tick();
    apb_write(8, 32'h203);
    apb_write(10, 32'h106);
    check_out("b2b_pre", 1, 8, 2);
    ack = 1; ack_id = 8; irq[10] = 1; tick(); ack = 0; ack_id = 0; irq[10] = 0;
    check_out("b2b_swap", 1, 10, 1);
    apb_read(8, d, e);
    total++;
    if (d !== 32'h202) begin
      bad++; $display("FAIL b2b_ip8 got %h exp %h", d, 32'h202);
    end
    apb_write(10, 0); apb_write(8, 0);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e;
    tick();
    apb_write(64, 1);
    apb_write(2, 32'h403);
    check_out("rst_pre", 1, 2, 4);
    rst_n = 0; ack = 1; ack_id = 2; tick(); rst_n = 1; ack = 0; ack_id = 0;
    check_out("rst_mid_out", 0, 0, 0);
    apb_read(2, d, e);
    total++;
    if ({e, d} !== 33'h0) begin
      bad++; $display("FAIL rst_mid_line2 got err=%b d=%h exp 0/0", e, d);
    end
    apb_read(64, d, e);
    total++;
    if ({e, d} !== 33'h0) begin
      bad++; $display("FAIL rst_mid_thresh got err=%b d=%h exp 0/0", e, d);
    end
    tick();
    check_out("rst_after", 0, 0, 0);
  endtask

  initial begin
    rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    irq = '0; ack = 0; ack_id = '0;
    #1;
    test_reset();
    test_edge();
    test_priority();
    test_thresh();
    test_level_ack();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
